// File: rtl/learning_neuron_seq.sv
// N-input fixed-point neuron with bias and enables: one MAC per cycle, selectable activation, in-place learning.
// Accept-to-out_valid is N+2 cycles; in_ready only in IDLE, err_ready only in HOLD, nothing is queued.
module learning_neuron_seq #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int INIT_W   = 128,
  parameter int LR_SHIFT = 2,
  parameter int ACT_MODE = 0,
  localparam int BIDX_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_INPUTS*DATA_W-1:0]   in_data,
  input  logic [N_INPUTS-1:0]          in_enable,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  input  logic                         err_valid,
  output logic                         err_ready,
  input  logic [DATA_W-1:0]            err_data,
  output logic                         back_valid,
  output logic [BIDX_W-1:0]            back_idx,
  output logic [DATA_W-1:0]            back_data,
  output logic                         busy
);

  localparam int IDX_W = $clog2(N_INPUTS + 1);
  localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] ONE   = DATA_W'(1 << FRAC_W);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_ACT, S_HOLD, S_BACK} state_t;

  function automatic logic signed [DATA_W-1:0] sat_wide(input logic signed [2*DATA_W-1:0] v);
    logic signed [2*DATA_W-1:0] hi, lo;
    hi = {{DATA_W{1'b0}}, MAX_V};
    lo = {{DATA_W{1'b1}}, MIN_V};
    if (v > hi) return MAX_V;
    if (v < lo) return MIN_V;
    return v[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] mul_q(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] ae, be, p;
    ae = {{DATA_W{a[DATA_W-1]}}, a};
    be = {{DATA_W{b[DATA_W-1]}}, b};
    p  = ae * be;
    return sat_wide(p >>> FRAC_W);
  endfunction

  function automatic logic signed [DATA_W-1:0] add_sat(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1]) return s[DATA_W] ? MIN_V : MAX_V;
    return s[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] activate(input logic signed [DATA_W-1:0] a);
    if (ACT_MODE == 1) return (a < 0) ? '0 : a;
    return (a >= 0) ? ONE : '0;
  endfunction

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic signed [DATA_W-1:0]   acc_q, acc_d;
  logic signed [DATA_W-1:0]   out_q, out_d;
  logic signed [DATA_W-1:0]   err_q, err_d;
  logic [N_INPUTS:0]          en_q, en_d;
  // Slot N holds the bias: input fixed at ONE and permanently enabled.
  logic signed [DATA_W-1:0]   x_q [N_INPUTS+1];
  logic signed [DATA_W-1:0]   x_d [N_INPUTS+1];
  logic signed [DATA_W-1:0]   w_q [N_INPUTS+1];
  logic signed [DATA_W-1:0]   w_d [N_INPUTS+1];
  logic signed [DATA_W-1:0]   mac_term, learn_term, back_term;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      err_q   <= '0;
      en_q    <= {1'b1, {N_INPUTS{1'b0}}};
      for (int i = 0; i <= N_INPUTS; i++) begin
        x_q[i] <= (i == N_INPUTS) ? ONE : '0;
        w_q[i] <= DATA_W'(INIT_W);
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      err_q   <= err_d;
      en_q    <= en_d;
      for (int i = 0; i <= N_INPUTS; i++) begin
        x_q[i] <= x_d[i];
        w_q[i] <= w_d[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_MAC;
      S_MAC:   if (idx_q == IDX_W'(N_INPUTS - 1)) state_d = S_ACT;
      S_ACT:   state_d = S_HOLD;
      S_HOLD:  if (err_valid) state_d = S_BACK;
      S_BACK:  if (idx_q == IDX_W'(N_INPUTS)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d      = acc_q;
    out_d      = out_q;
    err_d      = err_q;
    idx_d      = idx_q;
    en_d       = en_q;
    x_d        = x_q;
    w_d        = w_q;
    mac_term   = mul_q(x_q[idx_q], w_q[idx_q]);
    learn_term = mul_q(err_q, x_q[idx_q]) >>> LR_SHIFT;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < N_INPUTS; i++) x_d[i] = in_data[i*DATA_W +: DATA_W];
          en_d  = {1'b1, in_enable};
          acc_d = w_q[N_INPUTS];
          idx_d = '0;
        end
      end
      S_MAC: begin
        if (en_q[idx_q]) acc_d = add_sat(acc_q, mac_term);
        idx_d = idx_q + IDX_W'(1);
      end
      S_ACT: out_d = activate(acc_q);
      S_HOLD: begin
        if (err_valid) begin
          err_d = err_data;
          idx_d = '0;
        end
      end
      S_BACK: begin
        if (en_q[idx_q]) w_d[idx_q] = add_sat(w_q[idx_q], learn_term);
        idx_d = idx_q + IDX_W'(1);
      end
      default: idx_d = '0;
    endcase
  end

  // back_term is read before the weight register updates, so it uses the pre-update weight.
  always_comb begin
    back_term  = mul_q(err_q, w_q[idx_q]);
    in_ready   = (state_q == S_IDLE);
    err_ready  = (state_q == S_HOLD);
    out_valid  = (state_q == S_HOLD);
    busy       = (state_q != S_IDLE);
    back_valid = (state_q == S_BACK) && (idx_q < IDX_W'(N_INPUTS));
    back_idx   = back_valid ? idx_q[BIDX_W-1:0] : '0;
    back_data  = (back_valid && en_q[idx_q]) ? back_term : '0;
  end

  assign out_data = out_q;

endmodule

// File: tb/tb_learning_neuron_seq.sv
// Two neurons (ReLU and step) share every input; a plain-arithmetic model predicts outputs and learning.
module tb_learning_neuron_seq;
  localparam int N = 4, W = 16, FRAC = 8, INIT = 128, LR = 2, ONE = 256;
  typedef int vec_t [N];

  logic clk = 1'b0;
  logic reset, in_valid, err_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_enable;
  logic [W-1:0]   err_data;
  logic r_in_ready, r_out_valid, r_err_ready, r_back_valid, r_busy;
  logic s_in_ready, s_out_valid, s_err_ready, s_back_valid, s_busy;
  logic [1:0]   r_back_idx, s_back_idx;
  logic [W-1:0] r_out_data, s_out_data, r_back_data, s_back_data;

  always #5 clk = ~clk;

  learning_neuron_seq #(.N_INPUTS(N), .DATA_W(W), .FRAC_W(FRAC), .INIT_W(INIT), .LR_SHIFT(LR), .ACT_MODE(1)) u_relu (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r_in_ready), .in_data(in_data),
    .in_enable(in_enable), .out_valid(r_out_valid), .out_data(r_out_data), .err_valid(err_valid),
    .err_ready(r_err_ready), .err_data(err_data), .back_valid(r_back_valid), .back_idx(r_back_idx),
    .back_data(r_back_data), .busy(r_busy));

  learning_neuron_seq #(.N_INPUTS(N), .DATA_W(W), .FRAC_W(FRAC), .INIT_W(INIT), .LR_SHIFT(LR), .ACT_MODE(0)) u_step (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .in_enable(in_enable), .out_valid(s_out_valid), .out_data(s_out_data), .err_valid(err_valid),
    .err_ready(s_err_ready), .err_data(err_data), .back_valid(s_back_valid), .back_idx(s_back_idx),
    .back_data(s_back_data), .busy(s_busy));

  int n_checks = 0;
  int n_fail   = 0;
  longint w_m [N+1];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint mulq(input longint a, input longint b);
    return sat((a * b) >>> FRAC);
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= N; i++) w_m[i] = INIT;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; err_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", r_out_valid, 0);
    check("rst_out_data", r_out_data, 0);
    check("rst_busy", r_busy, 0);
    check("rst_back_valid", r_back_valid, 0);
    reset = 1'b0;
    check("rst_in_ready", r_in_ready, 1);
    model_reset();
  endtask

  task automatic abort_now();
    reset = 1'b1; in_valid = 1'b0; err_valid = 1'b0;
    @(negedge clk);
    check("abort_out_valid", r_out_valid, 0);
    check("abort_back_valid", r_back_valid, 0);
    check("abort_busy", r_busy | s_busy, 0);
    reset = 1'b0;
    model_reset();
  endtask

  // abort: 0 none, 1 reset mid-MAC, 2 reset mid-BACK
  task automatic run(input vec_t x, input logic [N-1:0] en, input int err, input int hold_n,
                     input bit hold_in, input int abort, output longint relu_o, output longint step_o);
    longint acc, er, es, first;
    longint bk [N];
    int cyc;
    bit stable;
    relu_o = 0; step_o = 0;
    acc = w_m[N];
    for (int i = 0; i < N; i++) if (en[i]) acc = sat(acc + mulq(x[i], w_m[i]));
    er = (acc < 0) ? 0 : acc;
    es = (acc >= 0) ? ONE : 0;

    @(negedge clk);
    check("idle_in_ready", r_in_ready, 1);
    in_valid = 1'b1; in_enable = en;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 16'(x[i]);
    @(negedge clk);
    if (!hold_in) in_valid = 1'b0;
    check("mac_in_ready", r_in_ready, 0);
    check("mac_busy", r_busy, 1);
    if (abort == 1) begin
      @(negedge clk);
      abort_now();
      return;
    end
    cyc = 1;
    while (!r_out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, N + 2);
    relu_o = longint'($signed(r_out_data));
    step_o = longint'($signed(s_out_data));
    check("relu_out", relu_o, er);
    check("step_out", step_o, es);
    first = relu_o; stable = 1'b1;
    for (int k = 0; k < hold_n; k++) begin
      @(negedge clk);
      if (longint'($signed(r_out_data)) != first || !r_out_valid || r_in_ready || !r_err_ready) stable = 1'b0;
    end
    if (hold_n > 0) check("hold_stable", stable, 1);

    in_valid = 1'b0; err_valid = 1'b1; err_data = 16'(err);
    @(negedge clk);
    err_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      bk[i] = en[i] ? mulq(err, w_m[i]) : 0;
      if (en[i]) w_m[i] = sat(w_m[i] + (mulq(err, x[i]) >>> LR));
    end
    w_m[N] = sat(w_m[N] + (mulq(err, ONE) >>> LR));
    for (int k = 0; k <= N; k++) begin
      if (abort == 2 && k == 2) begin
        abort_now();
        return;
      end
      if (k < N) begin
        check("back_valid", r_back_valid, 1);
        check("back_idx", r_back_idx, k);
        check("back_data_relu", longint'($signed(r_back_data)), bk[k]);
        check("back_data_step", longint'($signed(s_back_data)), bk[k]);
      end else begin
        check("bias_back_valid", r_back_valid, 0);
      end
      @(negedge clk);
    end
    check("done_busy", r_busy, 0);
    check("done_in_ready", r_in_ready, 1);
  endtask

  initial begin
    vec_t x;
    longint ro, so;
    logic [N-1:0] en;
    int err;
    reset = 1'b1; in_valid = 1'b0; err_valid = 1'b0;
    in_data = '0; in_enable = '0; err_data = '0;
    do_reset();

    x = '{0, 0, 6656, 0};
    run(x, 4'hF, 0, 3, 1'b0, 0, ro, so);
    check("t1_relu", ro, 3456);
    check("t1_step", so, 256);
    run(x, 4'b1011, 0, 2, 1'b0, 0, ro, so);
    check("t2_relu_bias_only", ro, 128);
    run(x, 4'hF, -256, 1, 1'b0, 0, ro, so);
    run(x, 4'hF, 0, 1, 1'b0, 0, ro, so);
    check("t3_after_learn_step", so, 0);
    check("t3_after_learn_relu", ro, 0);

    do_reset();
    x = '{25600, 25600, 25600, 25600};
    run(x, 4'hF, 0, 1, 1'b0, 0, ro, so);
    check("t4_saturate", ro, 32767);

    err_valid = 1'b1; err_data = 16'hFF00;
    repeat (3) @(negedge clk);
    check("t5_idle_err_busy", r_busy, 0);
    check("t5_idle_err_ready", r_err_ready, 0);
    err_valid = 1'b0;
    run(x, 4'hF, 0, 12, 1'b1, 0, ro, so);

    do_reset();
    x = '{0, 0, 6656, 0};
    run(x, 4'hF, -256, 0, 1'b0, 1, ro, so);
    run(x, 4'hF, -256, 0, 1'b0, 2, ro, so);
    run(x, 4'hF, 0, 0, 1'b0, 0, ro, so);
    check("t6_after_abort", ro, 3456);

    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++) begin
        x[i] = int'($urandom_range(8191)) - 4096;
        if ($urandom_range(7) == 0) x[i] = int'($urandom_range(65535)) - 32768;
      end
      en  = 4'($urandom);
      err = int'($urandom_range(1023)) - 512;
      if ($urandom_range(3) == 0) err = 0;
      run(x, en, err, int'($urandom_range(4)), 1'($urandom_range(1)), 0, ro, so);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
